// File: rtl/ili9341_spi_responder_pkg.sv
// Shared opcodes, wire-level constants and types for the ILI9341 SPI responder.
package ili9341_spi_responder_pkg;

  localparam logic [7:0] SW_RESET_CMD            = 8'h01;
  localparam logic [7:0] READ_DISPLAY_STATUS_CMD = 8'h09;
  localparam logic [7:0] SLPOUT_CMD              = 8'h11;
  localparam logic [7:0] DISPON_CMD              = 8'h29;
  localparam logic [7:0] CASET_CMD               = 8'h2A;
  localparam logic [7:0] PASET_CMD               = 8'h2B;
  localparam logic [7:0] MEMWRITE_CMD            = 8'h2C;
  localparam logic [7:0] MADCTL_CMD              = 8'h36;
  localparam logic [7:0] COLMOD_CMD              = 8'h3A;

  localparam logic COMMAND_BIT = 1'b0;
  localparam logic DATA_BIT    = 1'b1;

  localparam logic [7:0]  COLMOD_RESET = 8'h66;
  localparam int unsigned RDDST_BITS   = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARAM,
    ST_MEMWR,
    ST_READ
  } state_e;

  typedef struct packed {
    logic [15:0] xs;
    logic [15:0] xe;
    logic [15:0] ys;
    logic [15:0] ye;
  } window_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ili9341_spi_responder_spi_slave_shifter.sv
// SPI mode-0 slave front end: input synchronisers, sck edge detect, byte
// receive and the MISO transmit shift register used for status reads.
module spi_slave_shifter
  import ili9341_spi_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  input  logic        dc,
  input  logic        dis_reset,
  input  logic        tx_load,
  input  logic        tx_clear,
  input  logic [39:0] tx_data,
  output logic        dis_rst_n_s,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        miso,
  output logic        tx_active
);

  logic [2:0]  sck_sync_q, sck_sync_d;
  logic [1:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [1:0]  dc_sync_q, dc_sync_d;
  logic [1:0]  dis_sync_q, dis_sync_d;

  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        byte_valid_q, byte_valid_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_dc_q, byte_dc_d;

  logic [39:0] tx_sr_q, tx_sr_d;
  logic [5:0]  tx_cnt_q, tx_cnt_d;
  logic        tx_active_q, tx_active_d;
  logic        miso_q, miso_d;

  logic        sck_rise, sck_fall, cs_high, mosi_s, dc_s;

  assign sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_high     = cs_sync_q[1];
  assign mosi_s      = mosi_sync_q[1];
  assign dc_s        = dc_sync_q[1];
  assign dis_rst_n_s = dis_sync_q[1];

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_dc    = byte_dc_q;
  assign miso       = miso_q;
  assign tx_active  = tx_active_q;

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], sck};
    cs_sync_d   = {cs_sync_q[0], cs_n};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    dc_sync_d   = {dc_sync_q[0], dc};
    dis_sync_d  = {dis_sync_q[0], dis_reset};
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    if (!dis_rst_n_s) begin
      bit_cnt_d   = '0;
      shift_d     = '0;
      byte_data_d = '0;
      byte_dc_d   = 1'b0;
    end else if (cs_high) begin
      bit_cnt_d = '0;
    end else if (sck_rise) begin
      shift_d   = {shift_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = {shift_q, mosi_s};
        byte_dc_d    = dc_s;
      end
    end
  end

  // The first falling edge after load presents the first dummy bit; the one
  // after the last status bit returns miso to 0 and ends the transfer.
  always_comb begin
    tx_sr_d     = tx_sr_q;
    tx_cnt_d    = tx_cnt_q;
    tx_active_d = tx_active_q;
    miso_d      = miso_q;
    if (tx_clear || cs_high || !dis_rst_n_s) begin
      tx_sr_d     = '0;
      tx_cnt_d    = '0;
      tx_active_d = 1'b0;
      miso_d      = 1'b0;
    end else if (tx_load) begin
      tx_sr_d     = tx_data;
      tx_cnt_d    = 6'(RDDST_BITS);
      tx_active_d = 1'b1;
      miso_d      = 1'b0;
    end else if (sck_fall && tx_active_q) begin
      if (tx_cnt_q != '0) begin
        miso_d   = tx_sr_q[39];
        tx_sr_d  = {tx_sr_q[38:0], 1'b0};
        tx_cnt_d = tx_cnt_q - 6'd1;
      end else begin
        miso_d      = 1'b0;
        tx_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q   <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      dc_sync_q    <= '0;
      dis_sync_q   <= '1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_dc_q    <= 1'b0;
      tx_sr_q      <= '0;
      tx_cnt_q     <= '0;
      tx_active_q  <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      dc_sync_q    <= dc_sync_d;
      dis_sync_q   <= dis_sync_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
      tx_sr_q      <= tx_sr_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_active_q  <= tx_active_d;
      miso_q       <= miso_d;
    end
  end

endmodule

// File: rtl/ili9341_spi_responder.sv
// ILI9341 display-side SPI responder: command decode, init registers,
// CASET/PASET window, MEMWRITE pixel stream and RDDST status readback.
module ili9341_spi_responder
  import ili9341_spi_responder_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 12000000,
  parameter int unsigned DISPLAY_X    = 320,
  parameter int unsigned DISPLAY_Y    = 240,
  parameter int unsigned SWRESET_WAIT = max_u(4, SYS_CLK_FREQ / 200),
  parameter int unsigned SLPOUT_WAIT  = max_u(4, SYS_CLK_FREQ / 8)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dis_reset,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  input  logic        dc,
  output logic        miso,
  output logic        cmd_valid,
  output logic        data_valid,
  output logic [7:0]  rx_byte,
  output logic        pixel_valid,
  output logic [15:0] pixel,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        display_on,
  output logic        sleep_out,
  output logic [7:0]  madctl,
  output logic [7:0]  colmod,
  output logic        timing_err
);

  localparam window_t WIN_DEFAULT = '{
    xs: 16'd0, xe: 16'(DISPLAY_X - 1),
    ys: 16'd0, ye: 16'(DISPLAY_Y - 1)
  };

  logic        dis_rst_n_s, byte_valid, byte_dc, tx_active;
  logic [7:0]  byte_data;
  logic        tx_load, tx_clear;
  logic [39:0] tx_data;
  logic        is_cmd, is_data;

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [2:0]  param_idx_q, param_idx_d;
  logic [23:0] param_buf_q, param_buf_d;
  window_t     win_q, win_d;
  logic [15:0] cx_q, cx_d, cy_q, cy_d;
  logic [7:0]  pix_hi_q, pix_hi_d;
  logic        pix_half_q, pix_half_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [15:0] pixel_q, pixel_d, pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic        display_on_q, display_on_d, sleep_out_q, sleep_out_d;
  logic [7:0]  madctl_q, madctl_d, colmod_q, colmod_d;
  logic [31:0] lockout_q, lockout_d;

  spi_slave_shifter u_shifter (
    .clk         (clk),
    .reset       (reset),
    .sck         (sck),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .dc          (dc),
    .dis_reset   (dis_reset),
    .tx_load     (tx_load),
    .tx_clear    (tx_clear),
    .tx_data     (tx_data),
    .dis_rst_n_s (dis_rst_n_s),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_dc     (byte_dc),
    .miso        (miso),
    .tx_active   (tx_active)
  );

  assign is_cmd      = byte_valid && (byte_dc == COMMAND_BIT);
  assign is_data     = byte_valid && (byte_dc == DATA_BIT);
  assign cmd_valid   = is_cmd;
  assign data_valid  = is_data;
  assign rx_byte     = byte_data;
  // A lockout of 1 expires on this very edge, so that byte is on time.
  assign timing_err  = byte_valid && (lockout_q > 32'd1);
  assign pixel_valid = pixel_valid_q;
  assign pixel       = pixel_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign display_on  = display_on_q;
  assign sleep_out   = sleep_out_q;
  assign madctl      = madctl_q;
  assign colmod      = colmod_q;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    param_idx_d   = param_idx_q;
    param_buf_d   = param_buf_q;
    win_d         = win_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    pix_hi_d      = pix_hi_q;
    pix_half_d    = pix_half_q;
    pixel_valid_d = 1'b0;
    pixel_d       = pixel_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    display_on_d  = display_on_q;
    sleep_out_d   = sleep_out_q;
    madctl_d      = madctl_q;
    colmod_d      = colmod_q;
    lockout_d     = (lockout_q != '0) ? lockout_q - 32'd1 : '0;
    tx_load       = 1'b0;
    tx_clear      = 1'b0;
    tx_data       = {8'h00, madctl_q, colmod_q, 6'b0, sleep_out_q, display_on_q, 8'h00};

    if (state_q == ST_READ && !tx_active) begin
      state_d = ST_IDLE;
    end

    if (is_cmd) begin
      state_d     = ST_IDLE;
      cmd_d       = byte_data;
      param_idx_d = '0;
      pix_half_d  = 1'b0;
      tx_clear    = 1'b1;
      case (byte_data)
        SW_RESET_CMD: begin
          display_on_d = 1'b0;
          sleep_out_d  = 1'b0;
          madctl_d     = '0;
          colmod_d     = COLMOD_RESET;
          win_d        = WIN_DEFAULT;
          pixel_d      = '0;
          pixel_x_d    = '0;
          pixel_y_d    = '0;
          lockout_d    = SWRESET_WAIT;
        end
        SLPOUT_CMD: begin
          sleep_out_d = 1'b1;
          lockout_d   = SLPOUT_WAIT;
        end
        DISPON_CMD: display_on_d = 1'b1;
        MADCTL_CMD, COLMOD_CMD, CASET_CMD, PASET_CMD: state_d = ST_PARAM;
        MEMWRITE_CMD: begin
          state_d = ST_MEMWR;
          cx_d    = win_q.xs;
          cy_d    = win_q.ys;
        end
        READ_DISPLAY_STATUS_CMD: begin
          state_d  = ST_READ;
          tx_clear = 1'b0;
          tx_load  = 1'b1;
        end
        default: ;
      endcase
    end else if (is_data) begin
      case (state_q)
        ST_PARAM: begin
          if (param_idx_q != 3'd4) param_idx_d = param_idx_q + 3'd1;
          param_buf_d = {param_buf_q[15:0], byte_data};
          case (cmd_q)
            MADCTL_CMD: if (param_idx_q == 3'd0) madctl_d = byte_data;
            COLMOD_CMD: if (param_idx_q == 3'd0) colmod_d = byte_data;
            CASET_CMD: if (param_idx_q == 3'd3) begin
              win_d.xs = param_buf_q[23:8];
              win_d.xe = {param_buf_q[7:0], byte_data};
            end
            PASET_CMD: if (param_idx_q == 3'd3) begin
              win_d.ys = param_buf_q[23:8];
              win_d.ye = {param_buf_q[7:0], byte_data};
            end
            default: ;
          endcase
        end
        ST_MEMWR: begin
          if (!pix_half_q) begin
            pix_hi_d   = byte_data;
            pix_half_d = 1'b1;
          end else begin
            pix_half_d    = 1'b0;
            pixel_valid_d = 1'b1;
            pixel_d       = {pix_hi_q, byte_data};
            pixel_x_d     = cx_q;
            pixel_y_d     = cy_q;
            if (cx_q == win_q.xe) begin
              cx_d = win_q.xs;
              cy_d = (cy_q == win_q.ye) ? win_q.ys : cy_q + 16'd1;
            end else begin
              cx_d = cx_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !dis_rst_n_s) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      param_idx_q   <= '0;
      param_buf_q   <= '0;
      win_q         <= WIN_DEFAULT;
      cx_q          <= '0;
      cy_q          <= '0;
      pix_hi_q      <= '0;
      pix_half_q    <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_q       <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      display_on_q  <= 1'b0;
      sleep_out_q   <= 1'b0;
      madctl_q      <= '0;
      colmod_q      <= COLMOD_RESET;
      lockout_q     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      param_idx_q   <= param_idx_d;
      param_buf_q   <= param_buf_d;
      win_q         <= win_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      pix_hi_q      <= pix_hi_d;
      pix_half_q    <= pix_half_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_q       <= pixel_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      display_on_q  <= display_on_d;
      sleep_out_q   <= sleep_out_d;
      madctl_q      <= madctl_d;
      colmod_q      <= colmod_d;
      lockout_q     <= lockout_d;
    end
  end

endmodule
